// File: rtl/baud_gen_if.sv
// Rate-select / baud-clock bundle between the UART Tx control logic (master)
// and the baud generator (slave).
interface baud_gen_if;
   logic [1:0] baud_rate;
   logic       baud_clk;

   modport master (output baud_rate, input baud_clk);
   modport slave  (input baud_rate, output baud_clk);
endinterface

// File: rtl/baud_gen.sv
// Programmable baud clock generator: divides the system clock into a 50% duty
// square wave at 2400/4800/9600/19200 baud.
module baud_gen #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int HALF_2400  = 10417,
   parameter int HALF_4800  = 5208,
   parameter int HALF_9600  = 2604,
   parameter int HALF_19200 = 1302
) (
   input  logic       clock,
   input  logic       reset_n,
   baud_gen_if.slave  bus
);

   logic [13:0] cnt_q, cnt_d;
   logic        baud_clk_q, baud_clk_d;
   logic [13:0] half_m1;

   always_comb begin
      half_m1 = 14'(HALF_2400 - 1);
      case (bus.baud_rate)
         2'b00: half_m1 = 14'(HALF_2400 - 1);
         2'b01: half_m1 = 14'(HALF_4800 - 1);
         2'b10: half_m1 = 14'(HALF_9600 - 1);
         2'b11: half_m1 = 14'(HALF_19200 - 1);
         default: half_m1 = 14'(HALF_2400 - 1);
      endcase
   end

   // >= rather than == so a switch to a faster rate with a large count
   // toggles on the very next edge instead of running up to wrap-around.
   always_comb begin
      cnt_d      = cnt_q + 14'd1;
      baud_clk_d = baud_clk_q;
      if (cnt_q >= half_m1) begin
         cnt_d      = 14'd0;
         baud_clk_d = ~baud_clk_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= 14'd0;
         baud_clk_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         baud_clk_q <= baud_clk_d;
      end
   end

   assign bus.baud_clk = baud_clk_q;

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: reset behaviour, per-rate half-period
// lengths, rate switching and mid-period reset.
module tb_baud_gen;

   localparam int H2400  = 10417;
   localparam int H4800  = 5208;
   localparam int H9600  = 2604;
   localparam int H19200 = 1302;

   logic clock;
   logic reset_n;
   baud_gen_if bif ();

   baud_gen dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bif)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   typedef struct {
      logic [1:0] rate;
      int         half;
   } vec_t;

   vec_t vecs [3];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end else begin
         $display("ok   %s: %0d in %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Count rising clock edges until baud_clk changes; returns limit on timeout.
   task automatic wait_toggle(input int limit, output int n);
      logic prev;
      prev = bif.baud_clk;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (bif.baud_clk === prev && n < limit);
   endtask

   initial begin
      int n;
      int prev_half;

      vecs[0] = '{rate: 2'b01, half: H4800};
      vecs[1] = '{rate: 2'b10, half: H9600};
      vecs[2] = '{rate: 2'b11, half: H19200};

      // Reset held for 100 ns with the clock running
      reset_n = 1'b0;
      bif.baud_rate = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check($sformatf("reset_low_%0d", i), int'(bif.baud_clk), 0);
      end
      reset_n = 1'b1;   // t = 100 ns

      // 2400 baud: first rise, then high and low times
      wait_toggle(H2400 + 10, n);
      check("2400_first_rise", n, H2400);
      check("2400_level_after_rise", int'(bif.baud_clk), 1);
      wait_toggle(H2400 + 10, n);
      check("2400_high", n, H2400);
      wait_toggle(H2400 + 10, n);
      check("2400_low", n, H2400);

      // Rate sweep without reset
      prev_half = H2400;
      for (int v = 0; v < 3; v++) begin
         bif.baud_rate = vecs[v].rate;
         wait_toggle(prev_half + 10, n);
         check_range($sformatf("sweep%0d_transition", v), n, 1, prev_half);
         wait_toggle(vecs[v].half + 10, n);
         check($sformatf("sweep%0d_half_a", v), n, vecs[v].half);
         wait_toggle(vecs[v].half + 10, n);
         check($sformatf("sweep%0d_half_b", v), n, vecs[v].half);
         prev_half = vecs[v].half;
      end

      // Down-switch with a large count: 2400 at cnt=5000, then select 19200
      @(negedge clock);
      reset_n = 1'b0;
      bif.baud_rate = 2'b00;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 5000; i++) @(posedge clock);
      #1;
      check("down_no_toggle_yet", int'(bif.baud_clk), 0);
      bif.baud_rate = 2'b11;
      wait_toggle(H2400 + 10, n);
      check("down_next_edge_toggle", n, 1);
      wait_toggle(H19200 + 10, n);
      check("down_half_a", n, H19200);
      wait_toggle(H19200 + 10, n);
      check("down_half_b", n, H19200);

      // Reset pulse mid-period at 9600
      bif.baud_rate = 2'b10;
      if (bif.baud_clk !== 1'b1) wait_toggle(H9600 + 10, n);
      for (int i = 0; i < 700; i++) @(posedge clock);
      #1;
      check("pulse_high_before", int'(bif.baud_clk), 1);
      #4;
      reset_n = 1'b0;   // mid-cycle, well before the next edge
      #1;
      check("pulse_async_clear", int'(bif.baud_clk), 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      wait_toggle(H9600 + 10, n);
      check("pulse_first_rise", n, H9600);
      check("pulse_level_after_rise", int'(bif.baud_clk), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
